// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, debug and data-memory signals around the data-memory arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_lock;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_done;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_rdata, dbg_done,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_rdata, dbg_done,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin CPU/debug arbiter for the single data-memory port; 2 cycles req-to-done,
// one access per 2 cycles. The CPU is held off via a combinational stall; debug may lock the port.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SERVE_CPU = 2'd1;
  localparam logic [1:0] SERVE_DBG = 2'd2;
  localparam logic       OWNER_CPU = 1'b0;
  localparam logic       OWNER_DBG = 1'b1;

  logic [1:0]        state;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              last_owner;
  logic              lock_held;
  logic              cpu_done;
  logic              dbg_done;
  logic [DATA_W-1:0] cpu_rdata;
  logic [DATA_W-1:0] dbg_rdata;

  logic cpu_elig;
  logic dbg_elig;
  logic grant_cpu;
  logic grant_dbg;
  logic serving;

  // done masks the requester just served so a held req is not re-granted at once
  assign cpu_elig  = bus.cpu_req & ~cpu_done & ~lock_held;
  assign dbg_elig  = bus.dbg_req & ~dbg_done;
  assign grant_cpu = (state == IDLE) & cpu_elig & (~dbg_elig | (last_owner == OWNER_DBG));
  assign grant_dbg = (state == IDLE) & dbg_elig & ~grant_cpu;

  assign serving       = (state != IDLE);
  assign bus.mem_we    = serving & we_q;
  assign bus.mem_addr  = serving ? addr_q : '0;
  assign bus.mem_wdata = serving ? wdata_q : '0;

  assign bus.cpu_rdata = cpu_rdata;
  assign bus.cpu_done  = cpu_done;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_done;
  assign bus.dbg_rdata = dbg_rdata;
  assign bus.dbg_done  = dbg_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_owner <= OWNER_DBG;
      lock_held  <= 1'b0;
      cpu_done   <= 1'b0;
      dbg_done   <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      cpu_done <= 1'b0;
      dbg_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.dbg_lock) lock_held <= 1'b0;
          if (grant_cpu) begin
            state      <= SERVE_CPU;
            we_q       <= bus.cpu_we;
            addr_q     <= bus.cpu_addr;
            wdata_q    <= bus.cpu_wdata;
            last_owner <= OWNER_CPU;
          end else if (grant_dbg) begin
            state      <= SERVE_DBG;
            we_q       <= bus.dbg_we;
            addr_q     <= bus.dbg_addr;
            wdata_q    <= bus.dbg_wdata;
            last_owner <= OWNER_DBG;
            lock_held  <= bus.dbg_lock;
          end
        end
        SERVE_CPU: begin
          if (!we_q) cpu_rdata <= bus.mem_rdata;
          cpu_done <= 1'b1;
          state    <= IDLE;
        end
        SERVE_DBG: begin
          if (!we_q) dbg_rdata <= bus.mem_rdata;
          dbg_done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
